branch_predictor: RTL and testbench

Tournament branch predictor for the LC-3b pipeline. Looks up a prediction for the fetch-stage PC and emits the prediction bits and table indices that travel down the pipeline registers. Consumes those same fields (pred, local_index, global_index, br_taken) when the branch reaches MEM and trains its tables. This makes it the consuming end of the predictor fields carried by the pipeline registers.

---
 rtl/branch_predictor.sv | 74 +++++++
 tb/tb_branch_predictor.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - Tournament branch predictor: local, global and chooser tables of 2-bit counters
// Lookups are combinational off fetch_pc; training uses only the indices carried down the pipe.
module branch_predictor #(
  parameter int ls = 8,
  parameter int gs = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   fetch_pc,
  output logic          pred_taken,
  output logic [1:0]    pred,
  output logic [ls-1:0] local_index,
  output logic [gs-1:0] global_index,
  input  logic          upd_valid,
  input  logic          upd_taken,
  input  logic [1:0]    upd_pred,
  input  logic [ls-1:0] upd_local_index,
  input  logic [gs-1:0] upd_global_index,
  output logic [gs-1:0] ghr
);
  localparam int LN = 1 << ls;
  localparam int GN = 1 << gs;

  logic [1:0]    local_tab   [LN];
  logic [1:0]    global_tab  [GN];
  logic [1:0]    chooser_tab [GN];
  logic [gs-1:0] ghr_q;

  logic          local_pred;
  logic          global_pred;
  logic          local_correct;
  logic          global_correct;
  logic          unused_pc_bits;

  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic inc, input logic dec);
    if (inc && c != 2'b11) return c + 2'b01;
    if (dec && c != 2'b00) return c - 2'b01;
    return c;
  endfunction

  // Word-aligned PC: bit 0 never indexes, upper bits alias.
  assign unused_pc_bits = ^{fetch_pc[15:ls+1], fetch_pc[0]};

  assign local_index  = fetch_pc[ls:1];
  assign global_index = fetch_pc[gs:1] ^ ghr_q;
  assign local_pred   = local_tab[local_index][1];
  assign global_pred  = global_tab[global_index][1];
  assign pred         = {local_pred, global_pred};
  assign pred_taken   = chooser_tab[global_index][1] ? global_pred : local_pred;
  assign ghr          = ghr_q;

  assign local_correct  = (upd_pred[1] == upd_taken);
  assign global_correct = (upd_pred[0] == upd_taken);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LN; i++) local_tab[ls'(i)] <= 2'b01;
      for (int j = 0; j < GN; j++) begin
        global_tab[gs'(j)]  <= 2'b01;
        chooser_tab[gs'(j)] <= 2'b01;
      end
      ghr_q <= '0;
    end else if (upd_valid) begin
      local_tab[upd_local_index]    <= sat_step(local_tab[upd_local_index], upd_taken, !upd_taken);
      global_tab[upd_global_index]  <= sat_step(global_tab[upd_global_index], upd_taken, !upd_taken);
      // Chooser moves toward whichever component alone was right.
      chooser_tab[upd_global_index] <= sat_step(chooser_tab[upd_global_index],
                                                global_correct && !local_correct,
                                                local_correct && !global_correct);
      ghr_q <= {ghr_q[gs-2:0], upd_taken};
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - Randomized and directed check of branch_predictor against a counter-array model
module tb_branch_predictor;
  logic        clk;
  logic        reset;
  logic [15:0] fetch_pc;
  logic        pred_taken;
  logic [1:0]  pred;
  logic [7:0]  local_index;
  logic [5:0]  global_index;
  logic        upd_valid;
  logic        upd_taken;
  logic [1:0]  upd_pred;
  logic [7:0]  upd_local_index;
  logic [5:0]  upd_global_index;
  logic [5:0]  ghr;

  int n_checks = 0;
  int n_fail   = 0;

  int m_l [256];
  int m_g [64];
  int m_c [64];
  int m_h;

  branch_predictor #(.ls(8), .gs(6)) dut (
    .clk(clk), .reset(reset), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .pred(pred),
    .local_index(local_index), .global_index(global_index),
    .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_pred(upd_pred),
    .upd_local_index(upd_local_index), .upd_global_index(upd_global_index),
    .ghr(ghr)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 256; i++) m_l[i] = 1;
    for (int i = 0; i < 64; i++) begin
      m_g[i] = 1;
      m_c[i] = 1;
    end
    m_h = 0;
  endfunction

  function automatic int bump(input int c, input int d);
    int r;
    r = c + d;
    if (r > 3) r = 3;
    if (r < 0) r = 0;
    return r;
  endfunction

  function automatic void model_update(input int t, input int p, input int li, input int gi);
    int lc, gc, d;
    d  = t ? 1 : -1;
    lc = (((p >> 1) & 1) == t);
    gc = ((p & 1) == t);
    m_l[li] = bump(m_l[li], d);
    m_g[gi] = bump(m_g[gi], d);
    if (gc && !lc) m_c[gi] = bump(m_c[gi], 1);
    if (lc && !gc) m_c[gi] = bump(m_c[gi], -1);
    m_h = ((m_h * 2) + t) % 64;
  endfunction

  task automatic compare();
    int li, gi, lp, gp, pt;
    li = (fetch_pc / 2) % 256;
    gi = ((fetch_pc / 2) % 64) ^ m_h;
    lp = (m_l[li] >= 2);
    gp = (m_g[gi] >= 2);
    pt = (m_c[gi] >= 2) ? gp : lp;
    chk("local_index", local_index, li);
    chk("global_index", global_index, gi);
    chk("pred", pred, lp * 2 + gp);
    chk("pred_taken", pred_taken, pt);
    chk("ghr", ghr, m_h);
  endtask

  // Apply inputs at negedge, then check the pre-update lookup.
  task automatic drive(input logic [15:0] pc, input logic v, input logic t,
                       input logic [1:0] p, input logic [7:0] li, input logic [5:0] gi);
    @(negedge clk);
    reset = 0;
    fetch_pc = pc;
    upd_valid = v;
    upd_taken = t;
    upd_pred = p;
    upd_local_index = li;
    upd_global_index = gi;
    #1 compare();
  endtask

  task automatic clock();
    @(posedge clk);
    if (upd_valid && !reset) model_update(upd_taken, upd_pred, upd_local_index, upd_global_index);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    upd_valid = 0;
    model_reset();
    @(posedge clk);
  endtask

  initial begin
    reset = 1;
    fetch_pc = 16'h0010;
    upd_valid = 0;
    upd_taken = 0;
    upd_pred = 0;
    upd_local_index = 0;
    upd_global_index = 0;
    model_reset();
    #2;
    chk("reset_pred_taken", pred_taken, 0);
    chk("reset_pred", pred, 0);
    chk("reset_local_index", local_index, 8);
    chk("reset_global_index", global_index, 8);
    chk("reset_ghr", ghr, 0);
    @(posedge clk);

    // Local training
    drive(16'h0010, 1, 1, 2'b00, 8'd8, 6'd8); clock();
    drive(16'h0010, 1, 1, 2'b00, 8'd8, 6'd8); clock();
    drive(16'h0010, 0, 0, 2'b00, 8'd0, 6'd0);
    chk("train_ghr", ghr, 3);
    chk("train_global_index", global_index, 11);
    chk("train_pred", pred, 2);
    chk("train_pred_taken", pred_taken, 1);
    clock();

    // Chooser moves to global
    do_reset();
    drive(16'h0000, 1, 1, 2'b01, 8'd100, 6'd5); clock();
    drive(16'h0008, 0, 0, 2'b00, 8'd0, 6'd0);
    chk("chooser_global_index", global_index, 5);
    chk("chooser_pred", pred, 1);
    chk("chooser_pred_taken", pred_taken, 1);
    clock();

    // Saturation at 0 then climb
    do_reset();
    repeat (5) begin
      drive(16'h0006, 1, 0, 2'b00, 8'd3, 6'd0); clock();
    end
    drive(16'h0006, 1, 1, 2'b00, 8'd3, 6'd0); clock();
    drive(16'h0006, 0, 0, 2'b00, 8'd0, 6'd0);
    chk("sat_one_up_pred_taken", pred_taken, 0);
    clock();
    drive(16'h0006, 1, 1, 2'b00, 8'd3, 6'd0); clock();
    drive(16'h0006, 0, 0, 2'b00, 8'd0, 6'd0);
    chk("sat_two_up_global_index", global_index, 0);
    chk("sat_two_up_pred", pred, 3);
    chk("sat_two_up_pred_taken", pred_taken, 1);
    clock();

    // Same-cycle lookup and update: no bypass
    do_reset();
    drive(16'h0008, 1, 1, 2'b00, 8'd4, 6'd20);
    chk("collide_same_cycle", pred_taken, 0);
    clock();
    drive(16'h0008, 0, 0, 2'b00, 8'd0, 6'd0);
    chk("collide_next_cycle", pred_taken, 1);
    clock();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] pc;
      pc = 16'($urandom);
      if ($urandom_range(0, 3) != 0) pc[15:6] = 10'($urandom_range(0, 3));
      drive(pc, ($urandom_range(0, 2) != 0), 1'($urandom), 2'($urandom),
            8'($urandom_range(0, 31)), 6'($urandom));
      clock();
    end

    // Async reset between edges with an update pending
    drive(16'h0010, 1, 1, 2'b11, 8'd8, 6'd8);
    #2 reset = 1;
    model_reset();
    #1;
    chk("async_ghr", ghr, 0);
    chk("async_pred", pred, 0);
    chk("async_pred_taken", pred_taken, 0);
    compare();
    clock();
    drive(16'h0010, 0, 0, 2'b00, 8'd0, 6'd0);
    chk("post_reset_pred", pred, 0);
    chk("post_reset_ghr", ghr, 0);
    clock();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
